// File: rtl/operand_stack_if.sv
// Command/result bundle between the CPU control FSM (master) and the operand stack (slave).
// WIDTH and DEPTH must match the parameters of the attached operand_stack.
interface operand_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             op_done;
    logic             overflow;
    logic             underflow;
    logic [DW-1:0]    high_water;

    modport master (
        output op_valid, op, push_data,
        input  tos, nos, depth, empty, full, op_done, overflow, underflow, high_water
    );

    modport slave (
        input  op_valid, op, push_data,
        output tos, nos, depth, empty, full, op_done, overflow, underflow, high_water
    );
endinterface

// File: rtl/operand_stack.sv
// LIFO operand stack fed by the CPU control FSM.
// Commands are captured on one edge and executed on the next, so results and the
// op_done pulse appear one cycle after the capture edge; a command can be issued
// every cycle and each one sees the state left by its predecessor.
// Build option OPSTACK_STICKY_ERR_EN: when defined, overflow/underflow hold until
// reset or CLEAR; otherwise they pulse together with op_done of the refused command.
module operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    operand_stack_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_REPLACE = 3'b011;
    localparam logic [2:0] OP_DUP     = 3'b100;
    localparam logic [2:0] OP_SWAP    = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;

    localparam logic [DW-1:0] SP_ZERO = {DW{1'b0}};
    localparam logic [DW-1:0] SP_ONE  = DW'(1);
    localparam logic [DW-1:0] SP_TWO  = DW'(2);
    localparam logic [DW-1:0] SP_FULL = DW'(DEPTH);

    // Captured command (execute stage input)
    logic             cmd_valid_q;
    logic [2:0]       cmd_op_q;
    logic [WIDTH-1:0] cmd_data_q;

    // Architectural state
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DW-1:0]    sp_q,   sp_d;
    logic [DW-1:0]    hw_q,   hw_d;
    logic             done_q, done_d;
    logic             ovf_q,  ovf_d;
    logic             unf_q,  unf_d;

    // Execute-stage decode results
    logic             ovf_ev_s;
    logic             unf_ev_s;
    logic             clr_s;
    logic             wr0_en_s;
    logic [AW-1:0]    wr0_idx_s;
    logic [WIDTH-1:0] wr0_data_s;
    logic             wr1_en_s;
    logic [AW-1:0]    wr1_idx_s;
    logic [WIDTH-1:0] wr1_data_s;

    // Slot addresses derived from the pointer; only used when the guard allows it
    logic [AW-1:0]    push_idx_s;
    logic [AW-1:0]    top_idx_s;
    logic [AW-1:0]    nos_idx_s;
    logic [WIDTH-1:0] tos_raw_s;
    logic [WIDTH-1:0] nos_raw_s;

    assign push_idx_s = sp_q[AW-1:0];
    assign top_idx_s  = sp_q[AW-1:0] - AW'(1);
    assign nos_idx_s  = sp_q[AW-1:0] - AW'(2);
    assign tos_raw_s  = mem_q[top_idx_s];
    assign nos_raw_s  = mem_q[nos_idx_s];

    // Decode the captured command into pointer change, array writes and error events
    always_comb begin
        sp_d       = sp_q;
        done_d     = cmd_valid_q;
        ovf_ev_s   = 1'b0;
        unf_ev_s   = 1'b0;
        clr_s      = 1'b0;
        wr0_en_s   = 1'b0;
        wr0_idx_s  = push_idx_s;
        wr0_data_s = cmd_data_q;
        wr1_en_s   = 1'b0;
        wr1_idx_s  = nos_idx_s;
        wr1_data_s = tos_raw_s;
        if (cmd_valid_q) begin
            case (cmd_op_q)
                OP_PUSH: begin
                    if (sp_q == SP_FULL) begin
                        ovf_ev_s = 1'b1;
                    end else begin
                        wr0_en_s   = 1'b1;
                        wr0_idx_s  = push_idx_s;
                        wr0_data_s = cmd_data_q;
                        sp_d       = sp_q + SP_ONE;
                    end
                end
                OP_POP: begin
                    if (sp_q == SP_ZERO) begin
                        unf_ev_s = 1'b1;
                    end else begin
                        sp_d = sp_q - SP_ONE;
                    end
                end
                OP_REPLACE: begin
                    if (sp_q == SP_ZERO) begin
                        unf_ev_s = 1'b1;
                    end else begin
                        wr0_en_s   = 1'b1;
                        wr0_idx_s  = top_idx_s;
                        wr0_data_s = cmd_data_q;
                    end
                end
                OP_DUP: begin
                    // Empty check wins over the full check
                    if (sp_q == SP_ZERO) begin
                        unf_ev_s = 1'b1;
                    end else if (sp_q == SP_FULL) begin
                        ovf_ev_s = 1'b1;
                    end else begin
                        wr0_en_s   = 1'b1;
                        wr0_idx_s  = push_idx_s;
                        wr0_data_s = tos_raw_s;
                        sp_d       = sp_q + SP_ONE;
                    end
                end
                OP_SWAP: begin
                    if (sp_q < SP_TWO) begin
                        unf_ev_s = 1'b1;
                    end else begin
                        wr0_en_s   = 1'b1;
                        wr0_idx_s  = top_idx_s;
                        wr0_data_s = nos_raw_s;
                        wr1_en_s   = 1'b1;
                        wr1_idx_s  = nos_idx_s;
                        wr1_data_s = tos_raw_s;
                    end
                end
                OP_CLEAR: begin
                    sp_d  = SP_ZERO;
                    clr_s = 1'b1;
                end
                OP_NOP: begin
                    sp_d = sp_q;
                end
                default: begin
                    sp_d = sp_q;
                end
            endcase
        end else begin
            sp_d = sp_q;
        end
    end

    // Next values of the error flags and the high-water mark
    always_comb begin
`ifdef OPSTACK_STICKY_ERR_EN
        if (clr_s) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | ovf_ev_s;
            unf_d = unf_q | unf_ev_s;
        end
`else
        ovf_d = ovf_ev_s;
        unf_d = unf_ev_s;
`endif
        if (sp_d > hw_q) begin
            hw_d = sp_d;
        end else begin
            hw_d = hw_q;
        end
    end

    // Command capture and control/status state, synchronous reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= 3'b000;
            cmd_data_q  <= {WIDTH{1'b0}};
            sp_q        <= SP_ZERO;
            hw_q        <= SP_ZERO;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            cmd_valid_q <= bus.op_valid;
            cmd_op_q    <= bus.op;
            cmd_data_q  <= bus.push_data;
            sp_q        <= sp_d;
            hw_q        <= hw_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Stack array: up to two writes per cycle (SWAP uses both); contents need no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr0_en_s && (wr0_idx_s == AW'(i))) begin
                mem_q[i] <= wr0_data_s;
            end else if (wr1_en_s && (wr1_idx_s == AW'(i))) begin
                mem_q[i] <= wr1_data_s;
            end else begin
                mem_q[i] <= mem_q[i];
            end
        end
    end

    assign bus.tos        = (sp_q != SP_ZERO) ? tos_raw_s : {WIDTH{1'b0}};
    assign bus.nos        = (sp_q >= SP_TWO)  ? nos_raw_s : {WIDTH{1'b0}};
    assign bus.depth      = sp_q;
    assign bus.empty      = (sp_q == SP_ZERO);
    assign bus.full       = (sp_q == SP_FULL);
    assign bus.op_done    = done_q;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = unf_q;
    assign bus.high_water = hw_q;
endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack (WIDTH=8, DEPTH=16); honours OPSTACK_STICKY_ERR_EN.
module tb_operand_stack;
    localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, REPL = 3'b011;
    localparam logic [2:0] DUP = 3'b100, SWAP = 3'b101, CLR = 3'b110, RSV = 3'b111;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    operand_stack_if #(.WIDTH(8), .DEPTH(16)) bus ();

    operand_stack #(.WIDTH(8), .DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one command at a falling edge; return at the falling edge where its results show
    task automatic do_op(input logic [2:0] o, input logic [7:0] d);
        bus.op_valid  = 1'b1;
        bus.op        = o;
        bus.push_data = d;
        @(negedge clk);
        bus.op_valid  = 1'b0;
        bus.op        = NOP;
        bus.push_data = 8'h00;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.depth !== 5'd0) begin errors++; $display("FAIL rst_depth: got %0d expected 0", bus.depth); end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL rst_empty_full: got %b%b expected 10", bus.empty, bus.full); end
        checks++; if (bus.op_done !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL rst_flags: got %b%b%b expected 000", bus.op_done, bus.overflow, bus.underflow); end
        checks++; if (bus.high_water !== 5'd0 || bus.tos !== 8'h00 || bus.nos !== 8'h00) begin errors++; $display("FAIL rst_hw_tos_nos: got %0d %h %h expected 0 00 00", bus.high_water, bus.tos, bus.nos); end
    endtask

    task automatic test_back_to_back();
        bus.op_valid = 1'b1; bus.op = PUSH; bus.push_data = 8'h11;
        @(negedge clk);
        checks++; if (bus.depth !== 5'd0 || bus.op_done !== 1'b0) begin errors++; $display("FAIL b2b_latency: got depth %0d done %b expected 0 0", bus.depth, bus.op_done); end
        bus.push_data = 8'h22;
        @(negedge clk);
        bus.push_data = 8'h33;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op = NOP; bus.push_data = 8'h00;
        @(negedge clk);
        checks++; if (bus.op_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", bus.op_done); end
        checks++; if (bus.depth !== 5'd3 || bus.empty !== 1'b0) begin errors++; $display("FAIL b2b_depth: got %0d empty %b expected 3 0", bus.depth, bus.empty); end
        checks++; if (bus.tos !== 8'h33 || bus.nos !== 8'h22) begin errors++; $display("FAIL b2b_tos_nos: got %h %h expected 33 22", bus.tos, bus.nos); end
        checks++; if (bus.high_water !== 5'd3) begin errors++; $display("FAIL b2b_hw: got %0d expected 3", bus.high_water); end
        @(negedge clk);
        checks++; if (bus.op_done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse: got %b expected 0", bus.op_done); end
    endtask

    task automatic test_swap_pop();
        do_op(SWAP, 8'h00);
        checks++; if (bus.tos !== 8'h22 || bus.nos !== 8'h33 || bus.depth !== 5'd3) begin errors++; $display("FAIL swap: got %h %h d%0d expected 22 33 d3", bus.tos, bus.nos, bus.depth); end
        do_op(POP, 8'h00);
        checks++; if (bus.tos !== 8'h33 || bus.nos !== 8'h11) begin errors++; $display("FAIL pop1: got %h %h expected 33 11", bus.tos, bus.nos); end
        do_op(POP, 8'h00);
        do_op(POP, 8'h00);
        checks++; if (bus.depth !== 5'd0 || bus.empty !== 1'b1 || bus.tos !== 8'h00 || bus.op_done !== 1'b1) begin errors++; $display("FAIL pop_to_empty: got d%0d e%b tos %h done %b expected d0 e1 00 1", bus.depth, bus.empty, bus.tos, bus.op_done); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL pop_no_unf: got %b expected 0", bus.underflow); end
        do_op(POP, 8'h00);
        checks++; if (bus.underflow !== 1'b1 || bus.depth !== 5'd0 || bus.op_done !== 1'b1) begin errors++; $display("FAIL pop_underflow: got unf %b d%0d done %b expected 1 0 1", bus.underflow, bus.depth, bus.op_done); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            do_op(PUSH, 8'(i));
        end
        checks++; if (bus.depth !== 5'd15 || bus.full !== 1'b0) begin errors++; $display("FAIL full_pre: got d%0d full %b expected 15 0", bus.depth, bus.full); end
        do_op(PUSH, 8'h0F);
        checks++; if (bus.full !== 1'b1 || bus.op_done !== 1'b1 || bus.depth !== 5'd16) begin errors++; $display("FAIL full_set: got full %b done %b d%0d expected 1 1 16", bus.full, bus.op_done, bus.depth); end
        checks++; if (bus.tos !== 8'h0F || bus.nos !== 8'h0E || bus.high_water !== 5'd16) begin errors++; $display("FAIL full_tos: got %h %h hw%0d expected 0f 0e 16", bus.tos, bus.nos, bus.high_water); end
        do_op(PUSH, 8'hAA);
        checks++; if (bus.overflow !== 1'b1 || bus.tos !== 8'h0F || bus.depth !== 5'd16) begin errors++; $display("FAIL push_overflow: got ovf %b tos %h d%0d expected 1 0f 16", bus.overflow, bus.tos, bus.depth); end
        do_op(DUP, 8'h00);
        checks++; if (bus.overflow !== 1'b1 || bus.underflow !== 1'b0 || bus.depth !== 5'd16 || bus.nos !== 8'h0E) begin errors++; $display("FAIL dup_overflow: got ovf %b unf %b d%0d nos %h expected 1 0 16 0e", bus.overflow, bus.underflow, bus.depth, bus.nos); end
    endtask

    task automatic test_dup_replace();
        do_reset();
        do_op(DUP, 8'h00);
        checks++; if (bus.underflow !== 1'b1 || bus.overflow !== 1'b0 || bus.depth !== 5'd0) begin errors++; $display("FAIL dup_empty: got unf %b ovf %b d%0d expected 1 0 0", bus.underflow, bus.overflow, bus.depth); end
        do_reset();
        do_op(PUSH, 8'h05);
        do_op(DUP, 8'h00);
        checks++; if (bus.depth !== 5'd2 || bus.tos !== 8'h05 || bus.nos !== 8'h05) begin errors++; $display("FAIL dup: got d%0d %h %h expected 2 05 05", bus.depth, bus.tos, bus.nos); end
        do_op(REPL, 8'h07);
        checks++; if (bus.depth !== 5'd2 || bus.tos !== 8'h07 || bus.nos !== 8'h05) begin errors++; $display("FAIL replace: got d%0d %h %h expected 2 07 05", bus.depth, bus.tos, bus.nos); end
        do_op(POP, 8'h00);
        checks++; if (bus.depth !== 5'd1 || bus.tos !== 8'h05 || bus.nos !== 8'h00) begin errors++; $display("FAIL pop_d1: got d%0d %h %h expected 1 05 00", bus.depth, bus.tos, bus.nos); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL pop_d1_unf: got %b expected 0", bus.underflow); end
        do_op(SWAP, 8'h00);
        checks++; if (bus.underflow !== 1'b1 || bus.tos !== 8'h05 || bus.depth !== 5'd1) begin errors++; $display("FAIL swap_underflow: got unf %b tos %h d%0d expected 1 05 1", bus.underflow, bus.tos, bus.depth); end
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            do_op(PUSH, 8'(i));
        end
        do_op(CLR, 8'h00);
        checks++; if (bus.depth !== 5'd0 || bus.empty !== 1'b1 || bus.high_water !== 5'd5 || bus.op_done !== 1'b1) begin errors++; $display("FAIL clear: got d%0d e%b hw%0d done %b expected 0 1 5 1", bus.depth, bus.empty, bus.high_water, bus.op_done); end
        do_op(POP, 8'h00);
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL clr_pop_unf: got %b expected 1", bus.underflow); end
        @(negedge clk);
`ifdef OPSTACK_STICKY_ERR_EN
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL unf_hold: got %b expected 1", bus.underflow); end
        do_op(PUSH, 8'h01);
        checks++; if (bus.underflow !== 1'b1 || bus.depth !== 5'd1) begin errors++; $display("FAIL unf_sticky_push: got unf %b d%0d expected 1 1", bus.underflow, bus.depth); end
`else
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL unf_pulse: got %b expected 0", bus.underflow); end
        do_op(PUSH, 8'h01);
        checks++; if (bus.underflow !== 1'b0 || bus.depth !== 5'd1) begin errors++; $display("FAIL unf_after_push: got unf %b d%0d expected 0 1", bus.underflow, bus.depth); end
`endif
        do_op(CLR, 8'h00);
        checks++; if (bus.underflow !== 1'b0 || bus.depth !== 5'd0 || bus.high_water !== 5'd5) begin errors++; $display("FAIL clear2: got unf %b d%0d hw%0d expected 0 0 5", bus.underflow, bus.depth, bus.high_water); end
    endtask

    task automatic test_nop();
        do_op(PUSH, 8'h3C);
        do_op(NOP, 8'h99);
        checks++; if (bus.op_done !== 1'b1 || bus.depth !== 5'd1 || bus.tos !== 8'h3C) begin errors++; $display("FAIL nop: got done %b d%0d tos %h expected 1 1 3c", bus.op_done, bus.depth, bus.tos); end
        do_op(RSV, 8'h99);
        checks++; if (bus.op_done !== 1'b1 || bus.depth !== 5'd1 || bus.tos !== 8'h3C || bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL reserved: got done %b d%0d tos %h unf %b ovf %b expected 1 1 3c 0 0", bus.op_done, bus.depth, bus.tos, bus.underflow, bus.overflow); end
    endtask

    task automatic test_reset_mid();
        do_op(PUSH, 8'h44);
        checks++; if (bus.depth !== 5'd2) begin errors++; $display("FAIL mid_pre: got d%0d expected 2", bus.depth); end
        reset = 1'b1; bus.op_valid = 1'b1; bus.op = PUSH; bus.push_data = 8'h99;
        @(negedge clk);
        checks++; if (bus.depth !== 5'd0 || bus.high_water !== 5'd0 || bus.op_done !== 1'b0) begin errors++; $display("FAIL mid_reset: got d%0d hw%0d done %b expected 0 0 0", bus.depth, bus.high_water, bus.op_done); end
        reset = 1'b0; bus.op_valid = 1'b0; bus.op = NOP; bus.push_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.depth !== 5'd0 || bus.op_done !== 1'b0 || bus.tos !== 8'h00) begin errors++; $display("FAIL mid_no_write: got d%0d done %b tos %h expected 0 0 00", bus.depth, bus.op_done, bus.tos); end
    endtask

    initial begin
        reset         = 1'b1;
        bus.op_valid  = 1'b0;
        bus.op        = NOP;
        bus.push_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_swap_pop();
        test_full();
        test_dup_replace();
        test_clear();
        test_nop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- Hardware LIFO operand stack directly downstream of the CPU control FSM.
- Control issues single-cycle stack commands, and the stack returns top-of-stack and next-of-stack to the temp registers and ALU.
- Reports depth, full/empty, overflow/underflow and a high-water mark for debug.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, number of stack entries (>=2)
DW, $clog2(DEPTH+1), width of depth/pointer outputs (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
op_valid  input  1  command strobe, sampled each rising edge
op  input  3  command: 000 NOP, 001 PUSH, 010 POP, 011 REPLACE, 100 DUP, 101 SWAP, 110 CLEAR, 111 reserved (treated as NOP)
push_data  input  WIDTH  operand for PUSH/REPLACE
tos  output  WIDTH  top-of-stack entry (0 when empty)
nos  output  WIDTH  next-of-stack entry (0 when depth<2)
depth  output  DW  current entry count, 0..DEPTH
empty  output  1  depth==0
full  output  1  depth==DEPTH
op_done  output  1  one-cycle pulse acknowledging a sampled command
overflow  output  1  push-type command refused because the stack is full
underflow  output  1  command refused for insufficient entries
high_water  output  DW  maximum depth reached since reset

Behaviour:
- Storage: DEPTH x WIDTH register array plus stack pointer sp (== depth).
  - tos = mem[sp-1] and nos = mem[sp-2], driven combinationally from registers and gated to 0 per the rules above.
- Reset (highest priority, synchronous): sp=0, high_water=0, op_done=0, overflow=0, underflow=0.
  - Array contents are don't-care.
  - Any op_valid in a reset cycle is ignored.
- Latency: command sampled at edge N. Updated depth/tos/nos/flags and the op_done=1 pulse are all visible after edge N+1 and stay valid for one cycle.
  - A new command may be issued every cycle; back-to-back ops act on the updated state.
- Command semantics, with d = depth before the op:
  - PUSH: d<DEPTH → mem[d]=push_data, depth=d+1. d==DEPTH → no change, overflow.
  - POP: d>=1 → depth=d-1. d==0 → no change, underflow.
  - REPLACE: d>=1 → mem[d-1]=push_data, depth unchanged. d==0 → no change, underflow.
  - DUP: d==0 → underflow. d==DEPTH → overflow. Otherwise mem[d]=mem[d-1], depth=d+1. Underflow check takes precedence.
  - SWAP: d>=2 → exchange mem[d-1] and mem[d-2] in one cycle. Otherwise no change, underflow.
  - CLEAR: depth=0, flags cleared. high_water is not cleared.
  - NOP/111: no state change, op_done still pulses.
- A refused command never modifies the array or sp, and still produces op_done.
- high_water updates to the new depth whenever new depth > high_water.
- No wrap-around: sp saturates at 0 and DEPTH via the refusal rules.
- Boundaries:
  - PUSH at d=DEPTH-1 succeeds, and full asserts with op_done.
  - POP at d=1 asserts empty, and tos goes to 0 at the same time.

Optional Feature:
OPSTACK_STICKY_ERR_EN
- Defined: overflow/underflow are sticky. Once set, each stays 1 until reset or a CLEAR command. Later successful ops do not clear them.
- Undefined: overflow/underflow are one-cycle pulses coincident with the op_done of the refused command, otherwise 0.
- Port list is identical in both builds.

Test Plan:
- Reset, then PUSH 0x11, 0x22, 0x33 on consecutive cycles → after third op_done: depth=3, tos=0x33, nos=0x22, high_water=3, empty=0.
- From that state: SWAP → tos=0x22, nos=0x33. Then POP, POP, POP → depth=0, empty=1, tos=0. A fourth POP → underflow=1, depth stays 0.
- DEPTH=16: push 0x00..0x0F → full=1, depth=16. PUSH 0xAA → overflow=1, tos stays 0x0F. DUP → overflow=1.
- PUSH 0x05, DUP, REPLACE 0x07 → depth=2, tos=0x07, nos=0x05. SWAP with depth=1 after a POP → underflow=1, tos unchanged.
- Push 5 entries, CLEAR → depth=0, high_water=5.
  - Sticky build: underflow set by POP-on-empty stays 1 across a later PUSH 0x01, then clears on CLEAR.
  - Non-sticky build: same stimulus → underflow is a 1-cycle pulse.
- Assert reset mid-sequence with op_valid=1, op=PUSH → next cycle depth=0, high_water=0, op_done=0, no write.
